snake_body: RTL and testbench
=============================

// Module: snake_body
// PURPOSE
//  Upstream stage of the collision checker: owns one snake's segment array and advances it one grid cell per move tick.
//  Drives the 16x10-bit body bus consumed by collision_check; freezes on that block's stop flag.
//  Handles direction input with reversal rejection, growth on food, wall handling and a simple run/dead FSM.
//  Position encoding pos = {y[4:0], x[4:0]}; segment 0 is the head; unused segments hold SENTINEL 10'h3FF.
// PARAMETERS
//  INIT_POS  10'h0C5  head position after reset/restart (x=5, y=6)
//  INIT_LEN  3        initial length, 1..16; body laid out at x-1, x-2, ... on the same row
//  GRID_W    30       legal x range 0..GRID_W-1; must be <=31
//  GRID_H    30       legal y range 0..GRID_H-1; must be <=31
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        one-cycle pulse: IDLE->RUN, or DEAD->restart
//  tick       in   1        one-cycle move strobe
//  dir_valid  in   1        dir carries a new request
//  dir        in   2        0=up(y-1) 1=right(x+1) 2=down(y+1) 3=left(x-1)
//  grow       in   1        food eaten pulse; lengthens the body on the next move
//  stop       in   1        should_stop from collision_check for this snake
//  snake      out  16x10    segment positions, [0]=head
//  length     out  5        live segment count, 1..16
//  moved      out  1        one-cycle pulse the cycle after the segment array updates
//  alive      out  1        1 in RUN
//  wall_hit   out  1        sticky; set when the head would leave the grid (non-wrap build only)
// BEHAVIOUR
//  Reset: state IDLE. snake[i]=INIT_POS-i for i<INIT_LEN, else SENTINEL. cur_dir=pend_dir=1. length=INIT_LEN.
//   grow_pend=0. moved=0. alive=0. wall_hit=0.
//  FSM: IDLE --start--> RUN. RUN --stop | wall--> DEAD. DEAD --start--> reload reset image, go RUN. tick is ignored outside RUN.
//  Direction: dir_valid with dir != cur_dir^2 latches pend_dir. Reversals are dropped.
//   Several requests between ticks: the last legal one wins. Legality is checked against cur_dir, not pend_dir.
//  grow sets grow_pend in any state. grow_pend clears when the move that uses it happens.
//  Move, on a RUN tick with stop=0:
//   cur_dir<=pend_dir. nh = next head from pend_dir.
//   for i in 1..15: snake[i]<=snake[i-1] if i<length, or if i==length and grow_pend. Otherwise snake[i] keeps SENTINEL.
//   snake[0]<=nh.
//   length+1 if grow_pend and length<16. At length 16, grow is consumed and ignored (saturate).
//   moved=1 on the following cycle, so collision_check sees the new head one clock after moved and reports one further clock later.
//  stop and tick in the same cycle: stop wins. No move, go DEAD.
//  DEAD: snake/length frozen, alive=0, moved=0. dir_valid and grow requests still latch.
//  Restart clears wall_hit and grow_pend.
//  Arithmetic is on 5-bit fields only. No carry from x into y.
//  rst asserted at any time, including mid-move, restores the reset image asynchronously.
// CONFIGURATION
//  SNAKE_WRAP_EN defined: leaving the grid wraps. x=GRID_W-1 +right -> 0, x=0 +left -> GRID_W-1, same for y.
//   wall_hit stays 0.
//  SNAKE_WRAP_EN undefined: leaving the grid sets wall_hit=1 and goes DEAD. The array is not updated and moved stays 0.
// STRUCTURE
//  snake_pkg: pos_t (10b), dir_t enum (UP/RIGHT/DOWN/LEFT), SENTINEL=10'h3FF, MAX_LEN=16,
//   function reverse(dir_t), state_t (IDLE/RUN/DEAD).
//  Sub-module snake_next_head (combinational): in pos, dir. Out nh, off_grid. Wrap or flag selected by SNAKE_WRAP_EN.
// TESTING
//  1 Reset, start, 3 ticks, no dir -> snake[0..2] = 0C8,0C7,0C6; snake[3]=3FF; length=3; moved pulses 3 times.
//  2 Heading right, dir_valid dir=3 then tick -> request rejected, head x+1. dir=0 then dir=3 before the tick -> up taken (y-1).
//  3 grow pulse, tick -> length 4, old tail kept in snake[3]. Reach 16, then grow+tick -> length stays 16.
//  4 stop asserted with tick in the same cycle -> no move, alive=0. start -> reset image restored, alive=1.
//  5 Head x=29 heading right, tick -> wrap build: x=0, wall_hit=0. Non-wrap build: wall_hit=1, DEAD, snake unchanged.
//  6 rst pulsed during a RUN tick -> outputs equal the reset image immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body stage: positions, directions, FSM states.
package snake_pkg;

    typedef logic [9:0] pos_t;
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DEAD = 2'd2;

    localparam int   MAX_LEN  = 32'd16;
    localparam pos_t SENTINEL = 10'h3FF;

    typedef pos_t [MAX_LEN-1:0] body_t;

    // Opposite heading: up<->down and left<->right differ only in bit 1.
    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control and body bus between the snake body stage and its controller / collision checker.
interface snake_body_if;
    import snake_pkg::*;

    logic       start;
    logic       tick;
    logic       dir_valid;
    dir_t       dir;
    logic       grow;
    logic       stop;
    body_t      snake;
    logic [4:0] length;
    logic       moved;
    logic       alive;
    logic       wall_hit;

    modport master (
        output start, tick, dir_valid, dir, grow, stop,
        input  snake, length, moved, alive, wall_hit
    );

    modport slave (
        input  start, tick, dir_valid, dir, grow, stop,
        output snake, length, moved, alive, wall_hit
    );

endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head calculation on 5-bit x/y fields.
// SNAKE_WRAP_EN defined: grid edges wrap; otherwise off_grid flags an exit.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 30,
    parameter int GRID_H = 30
) (
    input  pos_t pos,
    input  dir_t dir,
    output pos_t nh,
    output logic off_grid
);

    localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
`ifdef SNAKE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    logic [4:0] x_s;
    logic [4:0] y_s;
    logic [4:0] nx_s;
    logic [4:0] ny_s;
    logic       edge_s;

    assign x_s = pos[4:0];
    assign y_s = pos[9:5];

    // Step one cell; at an edge produce the wrapped coordinate and flag the crossing.
    always_comb begin
        nx_s   = x_s;
        ny_s   = y_s;
        edge_s = 1'b0;
        case (dir)
            UP: begin
                if (y_s == 5'd0) begin
                    edge_s = 1'b1;
                    ny_s   = Y_MAX;
                end else begin
                    ny_s = y_s - 5'd1;
                end
            end
            RIGHT: begin
                if (x_s >= X_MAX) begin
                    edge_s = 1'b1;
                    nx_s   = 5'd0;
                end else begin
                    nx_s = x_s + 5'd1;
                end
            end
            DOWN: begin
                if (y_s >= Y_MAX) begin
                    edge_s = 1'b1;
                    ny_s   = 5'd0;
                end else begin
                    ny_s = y_s + 5'd1;
                end
            end
            LEFT: begin
                if (x_s == 5'd0) begin
                    edge_s = 1'b1;
                    nx_s   = X_MAX;
                end else begin
                    nx_s = x_s - 5'd1;
                end
            end
            default: begin
                nx_s   = x_s;
                ny_s   = y_s;
                edge_s = 1'b0;
            end
        endcase
    end

    assign nh       = {ny_s, nx_s};
    assign off_grid = edge_s & ~WRAP_EN;

endmodule

// File: rtl/snake_body.sv
// Snake segment array: direction filtering, growth, wall handling and IDLE/RUN/DEAD control.
// Wall behaviour selected by SNAKE_WRAP_EN (see snake_next_head).
module snake_body
    import snake_pkg::*;
#(
    parameter pos_t INIT_POS = 10'h0C5,
    parameter int   INIT_LEN = 3,
    parameter int   GRID_W   = 30,
    parameter int   GRID_H   = 30
) (
    input  logic         clk,
    input  logic         rst,
    snake_body_if.slave  bus
);

    function automatic body_t reset_image();
        body_t img;
        for (int i = 0; i < MAX_LEN; i++) begin
            img[i] = (i < INIT_LEN) ? pos_t'(INIT_POS - 10'(i)) : SENTINEL;
        end
        return img;
    endfunction

    localparam body_t      RESET_IMG = reset_image();
    localparam logic [4:0] RESET_LEN = 5'(INIT_LEN);
    localparam logic [4:0] FULL_LEN  = 5'(MAX_LEN);

    state_t     state_r;
    body_t      body_r;
    logic [4:0] length_r;
    dir_t       cur_dir_r;
    dir_t       pend_dir_r;
    logic       grow_pend_r;
    logic       moved_r;
    logic       alive_r;
    logic       wall_hit_r;

    pos_t       nh_s;
    logic       off_grid_s;
    logic       step_s;
    logic       do_move_s;
    logic       hit_wall_s;
    logic       restart_s;
    logic       dir_ok_s;
    body_t      shifted_s;
    logic [4:0] len_next_s;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_head (
        .pos      (body_r[0]),
        .dir      (pend_dir_r),
        .nh       (nh_s),
        .off_grid (off_grid_s)
    );

    // Legality is judged against the heading actually in use, not the pending one.
    assign dir_ok_s   = bus.dir_valid && (bus.dir != reverse(cur_dir_r));
    assign restart_s  = (state_r == DEAD) && bus.start;
    assign step_s     = (state_r == RUN) && bus.tick && !bus.stop;
    assign do_move_s  = step_s && !off_grid_s;
    assign hit_wall_s = step_s && off_grid_s;
    assign len_next_s = (grow_pend_r && (length_r < FULL_LEN)) ? (length_r + 5'd1) : length_r;

    // Shifted body: live segments follow their predecessor, the tail slot fills only when growing.
    always_comb begin
        shifted_s    = body_r;
        shifted_s[0] = nh_s;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < length_r) || ((5'(i) == length_r) && grow_pend_r)) begin
                shifted_s[i] = body_r[i-1];
            end else begin
                shifted_s[i] = body_r[i];
            end
        end
    end

    // FSM, segment array and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            body_r      <= RESET_IMG;
            length_r    <= RESET_LEN;
            cur_dir_r   <= RIGHT;
            pend_dir_r  <= RIGHT;
            grow_pend_r <= 1'b0;
            moved_r     <= 1'b0;
            alive_r     <= 1'b0;
            wall_hit_r  <= 1'b0;
        end else if (restart_s) begin
            state_r     <= RUN;
            body_r      <= RESET_IMG;
            length_r    <= RESET_LEN;
            cur_dir_r   <= RIGHT;
            pend_dir_r  <= RIGHT;
            grow_pend_r <= 1'b0;
            moved_r     <= 1'b0;
            alive_r     <= 1'b1;
            wall_hit_r  <= 1'b0;
        end else begin
            moved_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= RUN;
                        alive_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop || hit_wall_s) begin
                        state_r <= DEAD;
                        alive_r <= 1'b0;
                        if (hit_wall_s) begin
                            wall_hit_r <= 1'b1;
                        end
                    end else if (do_move_s) begin
                        body_r    <= shifted_s;
                        length_r  <= len_next_s;
                        cur_dir_r <= pend_dir_r;
                        moved_r   <= 1'b1;
                    end
                end
                DEAD: begin
                    alive_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    alive_r <= 1'b0;
                end
            endcase
            if (dir_ok_s) begin
                pend_dir_r <= bus.dir;
            end
            // A grow arriving on the consuming move is kept for the next one.
            if (do_move_s) begin
                grow_pend_r <= bus.grow;
            end else if (bus.grow) begin
                grow_pend_r <= 1'b1;
            end
        end
    end

    assign bus.snake    = body_r;
    assign bus.length   = length_r;
    assign bus.moved    = moved_r;
    assign bus.alive    = alive_r;
    assign bus.wall_hit = wall_hit_r;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with a queue-based reference model checked every cycle.
module tb_snake_body;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_body_if bus ();
    snake_body dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int mcount;

    // Reference model: body as a queue of positions, head first.
    int q[$];
    int m_state;   // 0 idle, 1 run, 2 dead
    int m_cur, m_pend, m_grow, m_wall, m_moved;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(32'h0C5 - i);
        m_state = 0; m_cur = 1; m_pend = 1; m_grow = 0; m_wall = 0; m_moved = 0;
    endtask

    function automatic logic [159:0] exp_vec();
        logic [159:0] v;
        for (int i = 0; i < 16; i++) v[i*10 +: 10] = (i < q.size()) ? 10'(q[i]) : 10'h3FF;
        return v;
    endfunction

    task automatic model_edge();
        int ocur, nx, ny;
        bit off, mv;
        if (rst) begin
            model_reset();
            return;
        end
        ocur = m_cur; m_moved = 0; mv = 0;
        if (m_state == 2 && bus.start) begin
            model_reset();
            m_state = 1;
            return;
        end
        if (m_state == 0 && bus.start) begin
            m_state = 1;
        end else if (m_state == 1 && bus.stop) begin
            m_state = 2;
        end else if (m_state == 1 && bus.tick) begin
            nx = q[0] % 32; ny = q[0] / 32;
            case (m_pend)
                0: ny = ny - 1;
                1: nx = nx + 1;
                2: ny = ny + 1;
                default: nx = nx - 1;
            endcase
            off = (nx < 0 || nx >= 30 || ny < 0 || ny >= 30);
`ifdef SNAKE_WRAP_EN
            nx = (nx + 30) % 30; ny = (ny + 30) % 30; off = 1'b0;
`endif
            if (off) begin
                m_wall = 1; m_state = 2;
            end else begin
                q.push_front(ny * 32 + nx);
                if (!(m_grow != 0 && q.size() <= 16)) void'(q.pop_back());
                m_cur = m_pend; m_moved = 1; mv = 1;
            end
        end
        if (mv) m_grow = int'(bus.grow);
        else if (bus.grow) m_grow = 1;
        if (bus.dir_valid && int'(bus.dir) != (ocur ^ 2)) m_pend = int'(bus.dir);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("snake", bus.snake, exp_vec());
            check("length", 160'(bus.length), 160'(q.size()));
            check("moved", 160'(bus.moved), 160'(m_moved));
            check("alive", 160'(bus.alive), 160'(m_state == 1));
            check("wall_hit", 160'(bus.wall_hit), 160'(m_wall));
        end
    end

    task automatic cyc(input logic st, input logic tk, input logic dv, input logic [1:0] d,
                       input logic gr, input logic sp);
        bus.start = st; bus.tick = tk; bus.dir_valid = dv; bus.dir = dir_t'(d);
        bus.grow = gr; bus.stop = sp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.start = 1'b0; bus.tick = 1'b0; bus.dir_valid = 1'b0; bus.grow = 1'b0; bus.stop = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.tick = 1'b0; bus.dir_valid = 1'b0; bus.dir = RIGHT;
        bus.grow = 1'b0; bus.stop = 1'b0;
        model_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_head", 160'(bus.snake[0]), 160'(10'h0C5));
        check("rst_seg2", 160'(bus.snake[2]), 160'(10'h0C3));
        check("rst_seg3", 160'(bus.snake[3]), 160'(10'h3FF));
        check("rst_len", 160'(bus.length), 160'(5'd3));
        check("rst_alive", 160'(bus.alive), 160'(1'b0));

        // Three plain moves to the right
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        mcount = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
            if (bus.moved) mcount++;
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            if (bus.moved) mcount++;
        end
        check("t1_moved_pulses", 160'(mcount), 160'(3));
        check("t1_head", 160'(bus.snake[0]), 160'(10'h0C8));
        check("t1_seg1", 160'(bus.snake[1]), 160'(10'h0C7));
        check("t1_seg2", 160'(bus.snake[2]), 160'(10'h0C6));
        check("t1_seg3", 160'(bus.snake[3]), 160'(10'h3FF));

        // Reversal rejected; last legal request wins, legality against cur_dir
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t2_reject", 160'(bus.snake[0]), 160'(10'h0C9));
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t2_up", 160'(bus.snake[0]), 160'(10'h0A9));

        // Growth and saturation at 16
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_len4", 160'(bus.length), 160'(5'd4));
        check("t3_tail", 160'(bus.snake[3]), 160'(10'h0C8));
        check("t3_head", 160'(bus.snake[0]), 160'(10'h089));
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        check("t3_len16", 160'(bus.length), 160'(5'd16));
        check("t3_head16", 160'(bus.snake[0]), 160'(10'h095));
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_sat", 160'(bus.length), 160'(5'd16));
        check("t3_sat_head", 160'(bus.snake[0]), 160'(10'h096));

        // stop beats tick; DEAD freezes; restart reloads
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        check("t4_alive", 160'(bus.alive), 160'(1'b0));
        check("t4_frozen", 160'(bus.snake[0]), 160'(10'h096));
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        check("t4_dead_tick", 160'(bus.snake[0]), 160'(10'h096));
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t4_restart_alive", 160'(bus.alive), 160'(1'b1));
        check("t4_restart_head", 160'(bus.snake[0]), 160'(10'h0C5));
        check("t4_restart_len", 160'(bus.length), 160'(5'd3));
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t4_no_grow", 160'(bus.length), 160'(5'd3));

        // Right edge: x=29 then one more step
        for (int k = 0; k < 23; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t5_edge", 160'(bus.snake[0]), 160'(10'h0DD));
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
        check("t5_wrap_head", 160'(bus.snake[0]), 160'(10'h0C0));
        check("t5_wrap_wall", 160'(bus.wall_hit), 160'(1'b0));
        check("t5_wrap_alive", 160'(bus.alive), 160'(1'b1));
`else
        check("t5_wall", 160'(bus.wall_hit), 160'(1'b1));
        check("t5_wall_alive", 160'(bus.alive), 160'(1'b0));
        check("t5_wall_head", 160'(bus.snake[0]), 160'(10'h0DD));
        check("t5_wall_moved", 160'(bus.moved), 160'(1'b0));
`endif
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t5_wall_clear", 160'(bus.wall_hit), 160'(1'b0));

        // Asynchronous reset in the middle of a tick cycle
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        bus.tick = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_head", 160'(bus.snake[0]), 160'(10'h0C5));
        check("t6_seg2", 160'(bus.snake[2]), 160'(10'h0C3));
        check("t6_seg3", 160'(bus.snake[3]), 160'(10'h3FF));
        check("t6_len", 160'(bus.length), 160'(5'd3));
        check("t6_alive", 160'(bus.alive), 160'(1'b0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.tick = 1'b0;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t6_after", 160'(bus.snake[0]), 160'(10'h0C6));

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
